// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: NOP encoding, fetch FSM states, buffer entry
// layout and the default reset PC.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned FETCH_DEPTH      = 2;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Clear the byte-offset bits so every fetch address is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer holding {pc, instr} pairs. Flush empties it in
// one cycle and takes priority over push and pop; push and pop may coincide
// at any occupancy, including full.
module fetch_fifo
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output logic         valid_o,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);

    fetch_entry_t mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    // Qualify push/pop against occupancy and compute next pointers and count.
    always_comb begin
        do_pop   = pop_i && (count_q != 2'd0);
        do_push  = push_i && ((count_q != 2'd2) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one word fetch at a time, buffers up to
// two returned instructions for decode, and handles redirects by flushing the
// buffer and discarding the single in-flight response if one is pending.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = FETCH_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fpc_q, fpc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic         outst_q, outst_d;

    logic         rsp_accept;
    logic         req;
    logic         fifo_push, fifo_pop;
    logic         fifo_valid;
    logic [1:0]   fifo_count;
    fetch_entry_t fifo_head, push_entry;

    // Request/response qualification plus next-state for FSM, fetch PC and outstanding flag.
    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        req_addr_d = req_addr_q;
        outst_d    = outst_q;

        // Responses without a pending request are stray strobes and ignored.
        rsp_accept = imem_rvalid && outst_q;
        // No request in a redirect cycle: it would fetch from the abandoned path.
        req        = rst_n && (state_q == S_FETCH) && !outst_q && !redirect_valid
                     && (({1'b0, fifo_count} + {2'b00, outst_q}) < 3'(DEPTH));
        fifo_push  = rsp_accept && (state_q == S_FETCH) && !redirect_valid;
        fifo_pop   = fifo_valid && instr_ready;
        push_entry = '{pc: req_addr_q, instr: imem_rdata};

        if (req) begin
            fpc_d      = fpc_q + 32'd4;
            req_addr_d = fpc_q;
            outst_d    = 1'b1;
        end else if (rsp_accept) begin
            outst_d = 1'b0;
        end

        if (redirect_valid) begin
            fpc_d = word_align(redirect_pc);
        end

        case (state_q)
            S_FETCH: begin
                if (redirect_valid && outst_q && !imem_rvalid) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (rsp_accept) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Control state: FSM, fetch PC and outstanding-request flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            fpc_q   <= RESET_PC;
            outst_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            outst_q <= outst_d;
        end
    end

    // Address of the outstanding request, attached to its response on push.
    always_ff @(posedge clk) begin
        req_addr_q <= req_addr_d;
    end

    fetch_fifo u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .valid_o     (fifo_valid),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign imem_req    = req;
    assign imem_addr   = fpc_q;
    assign instr_valid = fifo_valid;
    assign instr       = fifo_valid ? fifo_head.instr : NOP_INSTR;
    assign instr_pc    = fifo_valid ? fifo_head.pc    : 32'h0000_0000;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: DEPTH, 2, instruction buffer entries; only value 2 is supported.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_req  output  1  fetch request, accepted in the cycle it is high.
REQ-006 imem_addr  output  32  word-aligned fetch address, valid when imem_req=1.
REQ-007 imem_rvalid  input  1  response strobe, arrives 1 or more cycles after its request.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_rvalid=1.
REQ-009 redirect_valid  input  1  branch/jump taken this cycle.
REQ-010 redirect_pc  input  32  redirect target (PC+ImmExt from execute).
REQ-011 instr_valid  output  1  buffer head holds a valid instruction.
REQ-012 instr  output  32  head instruction; instr[31:7] drives the immediate extender.
REQ-013 instr_pc  output  32  address of head instruction.
REQ-014 instr_ready  input  1  decode consumes head when instr_valid=1 and instr_ready=1.

Function
REQ-015 Fetch PC register (fpc) SHALL hold next address to request; imem_addr = fpc.
REQ-016 At most one request SHALL be outstanding; imem_req=1 only when state=FETCH, no request outstanding, and (buffer count + outstanding) < DEPTH.
REQ-017 On imem_req=1, fpc SHALL advance by 4 the next cycle, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-018 A non-discarded response SHALL push {request address, imem_rdata} into the buffer in its imem_rvalid cycle; visible on instr the next cycle (request-to-instr_valid latency = memory latency + 1).
REQ-019 Buffer pop SHALL occur on instr_valid & instr_ready; simultaneous push and pop allowed when count=DEPTH... and at count 1 or 2 alike, order preserved.
REQ-020 When empty: instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=32'h0.
REQ-021 States: FETCH (normal), DRAIN (discard one in-flight response).
REQ-022 redirect_valid=1: buffer flushed, fpc <= {redirect_pc[31:2],2'b00}; if a request is outstanding and its response is not in the same cycle, next state DRAIN, else FETCH.
REQ-023 DRAIN: imem_req=0; on imem_rvalid the response SHALL be dropped and state -> FETCH next cycle.
REQ-024 Redirect coinciding with imem_rvalid: response dropped, no DRAIN entered.
REQ-025 Redirect coinciding with pop: redirect wins, buffer empty next cycle.
REQ-026 Redirect in DRAIN: fpc updated to new target, stay in DRAIN until the single in-flight response returns.
REQ-027 imem_rvalid with no outstanding request SHALL be ignored.

Reset
REQ-028 rst_n=0 SHALL immediately force: state=FETCH, fpc=RESET_PC, buffer empty, outstanding=0, imem_req=0 while rst_n=0.
REQ-029 First imem_req=1 with imem_addr=RESET_PC SHALL occur in the first clock edge cycle after rst_n deasserts; in-flight requests at reset are forgotten (memory is reset by the same rst_n).

Structure
REQ-030 Shared package riscv_pkg SHALL hold NOP_INSTR (32'h0000_0013), fetch state encoding, and RESET_PC default.
REQ-031 Buffer SHALL be a sub-module fetch_fifo (2-entry, {pc,instr} wide, with flush input).

Verification
REQ-032 Reset release, 1-cycle memory, instr_ready=1 -> addresses 0x0,0x4,0x8 issued on consecutive alternate cycles; instr_pc sequence 0x0,0x4,0x8 with matching rdata.
REQ-033 instr_ready=0 for 10 cycles -> exactly 2 instructions buffered, imem_req=0 afterwards; on release both delivered in order, no loss or duplication.
REQ-034 Redirect to 0x100 while request to 0x8 outstanding (3-cycle memory) -> response for 0x8 dropped, next imem_addr=0x100, instr_pc=0x100 first valid after redirect.
REQ-035 Redirect to 0x203 same cycle as imem_rvalid -> response dropped, no DRAIN, next imem_addr=0x200.
REQ-036 RESET_PC=32'hFFFF_FFFC -> second request address 0x0.
REQ-037 rst_n asserted mid-stream with 2 buffered entries -> instr_valid=0, instr=0x00000013 same cycle; restart at RESET_PC.
